// File: rtl/seg_display_scanner.sv
// seg_display_scanner: time-multiplexes four 8-bit segment patterns onto a
// 4-digit common-anode display. Anodes and cathodes are both active-low.
// Every digit slot starts with a blanking gap to suppress ghosting.
// Patterns are double-buffered, so a frame never shows a mix of old and new data.
// Optional build macro BRIGHTNESS_PWM_EN: adds a BRIGHTNESS[3:0] input that
// gates the lit anode with a free-running 4-bit PWM counter.
//
// state    | meaning
// ST_BLANK | slot counter inside the blanking gap, all anodes off
// ST_DRIVE | slot counter past the gap, the current digit may be lit
module seg_display_scanner #(
   parameter int REFRESH_DIV  = 50000,
   parameter int BLANK_CYCLES = 500
) (
   input  logic       CLK,
   input  logic       RST,
   input  logic [7:0] DIGIT_ONE,
   input  logic [7:0] DIGIT_TWO,
   input  logic [7:0] DIGIT_THREE,
   input  logic [7:0] DIGIT_FOUR,
   input  logic       LOAD,
   input  logic [3:0] DIGIT_EN,
`ifdef BRIGHTNESS_PWM_EN
   input  logic [3:0] BRIGHTNESS,
`endif
   output logic [3:0] AN,
   output logic [7:0] SEG,
   output logic       FRAME_START
);

   localparam int CW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
   localparam logic [CW-1:0] C_LAST  = CW'(REFRESH_DIV - 1);
   localparam logic [CW-1:0] C_BLANK = CW'(BLANK_CYCLES);

   typedef enum logic {
      ST_BLANK = 1'b0,
      ST_DRIVE = 1'b1
   } state_t;

   // With no blanking gap, slot 0 starts directly in DRIVE.
   localparam state_t ST_RST = (BLANK_CYCLES > 0) ? ST_BLANK : ST_DRIVE;

   state_t          state;
   logic [CW-1:0]   c;
   logic [CW-1:0]   c_nxt;
   logic [1:0]      d;
   logic            frame_seen;
   logic            slot_wrap;
   logic            frame_wrap;
   logic            pwm_on;
   logic            lit;
   logic [3:0][7:0] pend;
   logic [3:0][7:0] act;
   logic [3:0][7:0] din;
   logic            pend_vld;
   logic            have_data;
`ifdef BRIGHTNESS_PWM_EN
   logic [3:0]      p;
`endif

   assign din        = {DIGIT_FOUR, DIGIT_THREE, DIGIT_TWO, DIGIT_ONE};
   assign slot_wrap  = (c == C_LAST);
   assign frame_wrap = slot_wrap && (d == 2'd3);

   // Next slot count and the lit decision for the current (c, d).
   // Nothing lights until a pattern set has been committed since reset.
   always_comb begin
      c_nxt  = slot_wrap ? '0 : c + 1'b1;
`ifdef BRIGHTNESS_PWM_EN
      pwm_on = (p < BRIGHTNESS);
`else
      pwm_on = 1'b1;
`endif
      lit    = (state == ST_DRIVE) && DIGIT_EN[d] && have_data && pwm_on;
   end

   // Slot/digit sequencing, state tracking and registered display outputs.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         c           <= '0;
         d           <= 2'd0;
         state       <= ST_RST;
         frame_seen  <= 1'b0;
         AN          <= 4'hF;
         SEG         <= 8'hFF;
         FRAME_START <= 1'b0;
`ifdef BRIGHTNESS_PWM_EN
         p           <= 4'd0;
`endif
      end else begin
         c     <= c_nxt;
         state <= (c_nxt < C_BLANK) ? ST_BLANK : ST_DRIVE;
         if (slot_wrap) begin
            d <= d + 2'd1;
         end
         if (frame_wrap) begin
            frame_seen <= 1'b1;
         end
         FRAME_START <= (c == '0) && (d == 2'd0) && frame_seen;
         AN          <= lit ? ~(4'b0001 << d) : 4'hF;
         SEG         <= lit ? ~act[d] : 8'hFF;
`ifdef BRIGHTNESS_PWM_EN
         p           <= p + 4'd1;
`endif
      end
   end

   // Double buffer: LOAD fills pending, and the frame boundary commits it.
   // A LOAD on the boundary cycle itself goes straight to active.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         pend      <= '0;
         act       <= '0;
         pend_vld  <= 1'b0;
         have_data <= 1'b0;
      end else if (frame_wrap) begin
         if (LOAD) begin
            act       <= din;
            pend      <= din;
            have_data <= 1'b1;
         end else if (pend_vld) begin
            act       <= pend;
            have_data <= 1'b1;
         end
         pend_vld <= 1'b0;
      end else if (LOAD) begin
         pend     <= din;
         pend_vld <= 1'b1;
      end
   end

endmodule

// File: doc/seg_display_scanner.md
Name: seg_display_scanner

Overview:
Downstream stage of segment_translater. Takes the four translated 8-bit segment patterns and time-multiplexes them onto the Basys-2 4-digit common-anode display. Drives active-low anodes and cathodes with a programmable refresh rate and an inter-digit blanking gap to suppress ghosting. Holds a double-buffered pattern store so frames never tear.

Parameters:
REFRESH_DIV, 50000, clock cycles per digit slot; 1 kHz per digit, 250 Hz frame at 50 MHz; must be >= 2
BLANK_CYCLES, 500, cycles at the start of each slot with all anodes off; must be < REFRESH_DIV

Ports:
CLK  input  1  system clock
RST  input  1  asynchronous, active-high reset
DIGIT_ONE  input  8  segment pattern for digit 0 (rightmost), active-high, bit order {dp,g,f,e,d,c,b,a}
DIGIT_TWO  input  8  pattern for digit 1
DIGIT_THREE  input  8  pattern for digit 2
DIGIT_FOUR  input  8  pattern for digit 3 (leftmost)
LOAD  input  1  one-cycle strobe: capture all four DIGIT_* inputs
DIGIT_EN  input  4  per-digit enable; 0 keeps that digit dark for its whole slot
AN  output  4  anode drives, active-low
SEG  output  8  cathode drives, active-low, {dp,g,f,e,d,c,b,a}
FRAME_START  output  1  one-cycle pulse when slot 0 begins

Behaviour:
- Clocking: single clock CLK. RST is asynchronous, active-high. All outputs are registered.
- Reset values:
  - AN=4'b1111, SEG=8'hFF, FRAME_START=0.
  - Slot counter c=0, digit index d=0, state BLANK.
  - Pending and active pattern registers = 0; pending flag = 0.
- Slot counter c:
  - Counts 0..REFRESH_DIV-1 and wraps.
  - On wrap, d advances 0->1->2->3->0.
- State machine, two states, decoded from c:
  - BLANK (c < BLANK_CYCLES): AN=1111, SEG=FF.
  - DRIVE (c >= BLANK_CYCLES):
    - If DIGIT_EN[d]=1: AN has only bit d low; SEG = ~active[d].
    - If DIGIT_EN[d]=0: AN=1111, SEG=FF.
- Latency: AN/SEG reflect the (c,d) of the previous cycle, i.e. one-cycle register latency.
- DIGIT_EN is sampled every cycle. A change takes effect on the next cycle, even mid-slot.
- Double buffering:
  - LOAD=1 captures all four DIGIT_* inputs into the pending registers and sets the pending flag.
  - A later LOAD before commit overwrites pending (last one wins).
  - Commit happens on the cycle the slot 3->0 wrap occurs (frame boundary): pending is copied to active and the flag is cleared.
  - If LOAD coincides with the frame boundary, the DIGIT_* values present that cycle go directly to active and the flag ends cleared.
  - Active patterns never change mid-frame.
- FRAME_START:
  - High for exactly one cycle, registered, aligned with the first output cycle of slot 0.
  - Not asserted for the initial slot 0 after reset.
- Reset mid-slot: outputs go dark immediately (asynchronous). Pending/active data is lost; the display stays blank until a LOAD commits.

Optional Feature:
BRIGHTNESS_PWM_EN
- Defined:
  - Adds input port BRIGHTNESS [3:0] and a free-running 4-bit counter p, reset to 0.
  - In DRIVE, the digit's anode is asserted only when p < BRIGHTNESS.
  - BRIGHTNESS=0: always dark. BRIGHTNESS=15: lit 15 of every 16 cycles.
  - SEG is forced to FF whenever the anode is gated off.
- Not defined: the port is absent and DRIVE is full duty.

Test Plan:
All scenarios use REFRESH_DIV=8, BLANK_CYCLES=2.
1. Reset, then LOAD with DIGIT_ONE..FOUR = 3F,06,5B,4F and DIGIT_EN=1111, then run 2 frames.
   - Before the first frame boundary: AN=1111, SEG=FF (active regs are still 0).
   - After the boundary, each slot shows 2 cycles of AN=1111 then 6 cycles of AN=1110/C0, 1101/F9, 1011/A4, 0111/B0 in order.
   - FRAME_START pulses once per 32 cycles.
2. LOAD new data mid-frame (in slot 1).
   - Slots 1–3 keep the old patterns.
   - New patterns appear from the next slot 0.
3. Two LOADs in one frame (values A, then B).
   - Only B is displayed next frame.
   - LOAD on the exact boundary cycle is displayed in that same frame.
4. DIGIT_EN=1010.
   - Slots 0 and 2 stay AN=1111/SEG=FF throughout.
   - Slots 1 and 3 drive normally.
   - Toggling DIGIT_EN[3] mid-slot darkens AN[3] one cycle later.
5. Assert RST during DRIVE of slot 2.
   - AN=1111 and SEG=FF immediately, without waiting for a clock edge.
   - After release, the counter restarts at slot 0; display stays blank until a LOAD plus frame boundary.
6. With BRIGHTNESS_PWM_EN defined and BRIGHTNESS=4: in DRIVE the anode is low only when p is 0–3.
   - BRIGHTNESS=0: AN stays 1111 permanently.
